instruction_fetch: RTL

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

---
 rtl/instruction_fetch_pkg.sv | 43 ++++
 rtl/instruction_fetch_imm_gen.sv | 26 ++
 rtl/instruction_fetch.sv | 95 +++++++++
 3 files changed

// File: rtl/instruction_fetch_pkg.sv
// Shared RV32 opcode constants, NOP encoding, fetch FSM states and the immediate
// format classifier used by the fetch stage and the controller.
package instruction_fetch_pkg;

    localparam logic [6:0] LUI      = 7'b0110111;
    localparam logic [6:0] AUIPC    = 7'b0010111;
    localparam logic [6:0] JAL      = 7'b1101111;
    localparam logic [6:0] JALR     = 7'b1100111;
    localparam logic [6:0] BTYPE    = 7'b1100011;
    localparam logic [6:0] LOADS    = 7'b0000011;
    localparam logic [6:0] STORES   = 7'b0100011;
    localparam logic [6:0] ARITHM_I = 7'b0010011;
    localparam logic [6:0] ARITHM_R = 7'b0110011;

    // addi x0, x0, 0
    localparam logic [31:0] NOP = 32'h00000013;

    localparam logic [0:0] ST_REQ  = 1'b0;
    localparam logic [0:0] ST_HOLD = 1'b1;

    typedef enum logic [2:0] {
        IMM_NONE,
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J
    } imm_fmt_t;

    function automatic imm_fmt_t imm_format(input logic [6:0] opcode);
        imm_fmt_t fmt;
        case (opcode)
            LOADS, ARITHM_I, JALR: fmt = IMM_I;
            STORES:                fmt = IMM_S;
            BTYPE:                 fmt = IMM_B;
            LUI, AUIPC:            fmt = IMM_U;
            JAL:                   fmt = IMM_J;
            default:               fmt = IMM_NONE;
        endcase
        return fmt;
    endfunction

endpackage

// File: rtl/instruction_fetch_imm_gen.sv
// Combinational immediate decoder: expands the held instruction word into a
// sign-extended 32-bit immediate according to its opcode format.
module imm_gen
    import instruction_fetch_pkg::*;
(
    input  logic [31:0] ir,
    output logic [31:0] imm
);

    imm_fmt_t fmt;

    assign fmt = imm_format(ir[6:0]);

    always_comb begin
        imm = 32'h00000000;
        case (fmt)
            IMM_I: imm = {{20{ir[31]}}, ir[31:20]};
            IMM_S: imm = {{20{ir[31]}}, ir[31:25], ir[11:7]};
            IMM_B: imm = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
            IMM_U: imm = {ir[31:12], 12'h000};
            IMM_J: imm = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
            default: imm = 32'h00000000;
        endcase
    end

endmodule

// File: rtl/instruction_fetch.sv
// Two-state instruction fetch stage: issues one word fetch, holds the returned
// instruction with its decoded fields until downstream accepts it.
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h00000000
) (
    input  logic        CLK,
    input  logic        RST,
    output logic        IMEM_REQ,
    output logic [31:0] IMEM_ADDR,
    input  logic        IMEM_ACK,
    input  logic [31:0] IMEM_RDATA,
    input  logic        REDIRECT,
    input  logic [31:0] REDIRECT_PC,
    input  logic        NEXT_READY,
    output logic        INSTR_VALID,
    output logic [31:0] PC,
    output logic [6:0]  OPCODE,
    output logic [3:0]  FUNCT3,
    output logic [6:0]  FUNCT7,
    output logic [4:0]  RD,
    output logic [4:0]  RS1,
    output logic [4:0]  RS2,
    output logic [31:0] IMM
);

    localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

    logic [0:0]  state;
    logic [0:0]  state_next;
    logic [31:0] fetch_pc;
    logic [31:0] redirect_target;
    logic        capture;
    logic [31:0] ir_p1;
    logic [31:0] pc_p1;

    assign redirect_target = REDIRECT_PC & 32'hFFFFFFFC;

    // A returned word is taken only while a fetch is outstanding and not being redirected away.
    assign capture = (state == ST_REQ) && IMEM_ACK && !REDIRECT;

    always_comb begin
        state_next = state;
        if (REDIRECT) begin
            state_next = ST_REQ;
        end else begin
            case (state)
                ST_REQ:  if (IMEM_ACK)   state_next = ST_HOLD;
                ST_HOLD: if (NEXT_READY) state_next = ST_REQ;
                default: state_next = ST_REQ;
            endcase
        end
    end

    // Fetch/hold stage boundary
    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= ST_REQ;
            fetch_pc <= RESET_PC_ALIGNED;
            pc_p1    <= RESET_PC_ALIGNED;
            ir_p1    <= NOP;
        end else begin
            state <= state_next;
            if (REDIRECT) begin
                fetch_pc <= redirect_target;
            end else if (capture) begin
                fetch_pc <= fetch_pc + 32'd4;
            end
            if (capture) begin
                ir_p1 <= IMEM_RDATA;
                pc_p1 <= fetch_pc;
            end
        end
    end

    // Reset masks the handshake outputs immediately, before the state register settles.
    assign IMEM_REQ    = (state == ST_REQ) && !RST;
    assign INSTR_VALID = (state == ST_HOLD) && !RST;
    assign IMEM_ADDR   = fetch_pc;

    assign PC     = pc_p1;
    assign OPCODE = ir_p1[6:0];
    assign FUNCT3 = {1'b0, ir_p1[14:12]};
    assign FUNCT7 = ir_p1[31:25];
    assign RD     = ir_p1[11:7];
    assign RS1    = ir_p1[19:15];
    assign RS2    = ir_p1[24:20];

    imm_gen u_imm_gen (
        .ir  (ir_p1),
        .imm (IMM)
    );

endmodule
